// File: rtl/mem_arb_if.sv
// mem_arb_if: bundle of the shared 8-bit RAM port plus the IF and MM requester buses.
// slave modport  = arbiter side (drives RAM address/data and the ok/data returns).
// master modport = requester/RAM-model side (drives requests, store data and ram_din).
interface mem_arb_if;
  // RAM byte port
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  // instruction fetch requester
  logic        if_req;
  logic [31:0] if_a;
  logic        if_abort;
  logic        if_ok;
  logic [31:0] if_n;
  // memory stage requester
  logic        mm_req;
  logic        mm_wr;
  logic [31:0] mm_a;
  logic [1:0]  mm_cu;
  logic [31:0] mm_n_i;
  logic        mm_ok;
  logic [31:0] mm_n_o;

  modport slave (
    input  ram_din, if_req, if_a, if_abort, mm_req, mm_wr, mm_a, mm_cu, mm_n_i,
    output ram_dout, ram_a, ram_wr, if_ok, if_n, mm_ok, mm_n_o
  );

  modport master (
    output ram_din, if_req, if_a, if_abort, mm_req, mm_wr, mm_a, mm_cu, mm_n_i,
    input  ram_dout, ram_a, ram_wr, if_ok, if_n, mm_ok, mm_n_o
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: arbitrates IF and MM onto one 8-bit RAM port, splitting words into LE byte accesses.
// Latency: read of N bytes completes (ok) N+2 cycles after grant, write of N bytes N+1 cycles after.
// Backpressure: level requests are held off while a transaction runs; no ready, grant is implied by ok.
// Ports: clk/rst (sync, active-high); bus = mem_arb_if.slave carrying the RAM port, the IF fetch
// channel (req/addr/abort -> ok/word) and the MM channel (req/wr/addr/size/data -> ok/data).
module mem_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mem_arb_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   base, base_nxt;      // latched start address
  logic [2:0]    n, n_nxt;            // byte count of the current transaction
  logic [2:0]    cnt, cnt_nxt;        // cycles spent in RD/WR so far
  logic          who_if, who_if_nxt;  // 1 = current grantee is IF
  logic [31:0]   wdat, wdat_nxt;      // latched store data
  logic [31:0]   asm_q, asm_nxt;      // read assembly buffer
  logic [31:0]   if_hold, if_hold_nxt;
  logic [31:0]   mm_hold, mm_hold_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic [31:0]   ram_a_q, ram_a_nxt;
  logic [7:0]    ram_dout_q, ram_dout_nxt;
  logic          ram_wr_q, ram_wr_nxt;

  logic          if_vld;
  logic          grant_mm;
  logic          grant_if;
  logic [2:0]    mm_size;
  logic [2:0]    cnt_inc;
  logic [2:0]    cap_idx;
  logic          if_ok_c;
  logic          mm_ok_c;

  // An IF request raised together with abort does not count as a request.
  assign if_vld   = bus.if_req & ~bus.if_abort;
  assign grant_mm = bus.mm_req & (~if_vld | (streak != SW'(STARVE_MAX)));
  assign grant_if = if_vld & ~grant_mm;
  assign mm_size  = (bus.mm_cu == 2'd0) ? 3'd1 : (bus.mm_cu == 2'd1) ? 3'd2 : 3'd4;
  assign cnt_inc  = cnt + 3'd1;
  assign cap_idx  = cnt - 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      n          <= '0;
      cnt        <= '0;
      who_if     <= 1'b0;
      wdat       <= '0;
      asm_q      <= '0;
      if_hold    <= '0;
      mm_hold    <= '0;
      streak     <= '0;
      ram_a_q    <= '0;
      ram_dout_q <= '0;
      ram_wr_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      base       <= base_nxt;
      n          <= n_nxt;
      cnt        <= cnt_nxt;
      who_if     <= who_if_nxt;
      wdat       <= wdat_nxt;
      asm_q      <= asm_nxt;
      if_hold    <= if_hold_nxt;
      mm_hold    <= mm_hold_nxt;
      streak     <= streak_nxt;
      ram_a_q    <= ram_a_nxt;
      ram_dout_q <= ram_dout_nxt;
      ram_wr_q   <= ram_wr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    base_nxt     = base;
    n_nxt        = n;
    cnt_nxt      = cnt;
    who_if_nxt   = who_if;
    wdat_nxt     = wdat;
    asm_nxt      = asm_q;
    if_hold_nxt  = if_hold;
    mm_hold_nxt  = mm_hold;
    streak_nxt   = streak;
    // RAM port is quiet unless an issue cycle is scheduled below.
    ram_a_nxt    = '0;
    ram_dout_nxt = '0;
    ram_wr_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (grant_mm) begin
          base_nxt   = bus.mm_a;
          n_nxt      = mm_size;
          who_if_nxt = 1'b0;
          wdat_nxt   = bus.mm_n_i;
          asm_nxt    = '0;
          cnt_nxt    = '0;
          ram_a_nxt  = bus.mm_a;
          if (bus.if_req) begin
            if (streak != SW'(STARVE_MAX)) streak_nxt = streak + SW'(1);
          end else begin
            streak_nxt = '0;
          end
          if (bus.mm_wr) begin
            state_nxt    = WR;
            ram_wr_nxt   = 1'b1;
            ram_dout_nxt = bus.mm_n_i[7:0];
          end else begin
            state_nxt = RD;
          end
        end else if (grant_if) begin
          base_nxt   = bus.if_a;
          n_nxt      = 3'd4;
          who_if_nxt = 1'b1;
          asm_nxt    = '0;
          cnt_nxt    = '0;
          streak_nxt = '0;
          ram_a_nxt  = bus.if_a;
          state_nxt  = RD;
        end
      end

      RD: begin
        if (who_if && bus.if_abort) begin
          // Drop the fetch; the byte still in flight on ram_din is simply not captured.
          state_nxt = IDLE;
        end else begin
          // Cycle cnt issues byte cnt and captures byte cnt-1 (RAM has one cycle latency).
          if (cnt != 3'd0) begin
            asm_nxt = asm_q | ({24'h0, bus.ram_din} << {cap_idx, 3'b000});
          end
          if (cnt == n) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt_inc;
            if (cnt_inc < n) ram_a_nxt = base + {29'h0, cnt_inc};
          end
        end
      end

      WR: begin
        if (cnt_inc == n) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt      = cnt_inc;
          ram_a_nxt    = base + {29'h0, cnt_inc};
          ram_wr_nxt   = 1'b1;
          ram_dout_nxt = 8'(wdat >> {cnt_inc, 3'b000});
        end
      end

      DONE: begin
        state_nxt = IDLE;
        if (who_if) begin
          if (!bus.if_abort) if_hold_nxt = asm_q;
        end else begin
          mm_hold_nxt = asm_q;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ok is combinational so a late IF abort in DONE can still suppress it;
  // the data outputs show the fresh word during DONE and the held word otherwise.
  assign if_ok_c = (state == DONE) && who_if && !bus.if_abort;
  assign mm_ok_c = (state == DONE) && !who_if;

  assign bus.if_ok    = if_ok_c;
  assign bus.mm_ok    = mm_ok_c;
  assign bus.if_n     = if_ok_c ? asm_q : if_hold;
  assign bus.mm_n_o   = mm_ok_c ? asm_q : mm_hold;
  assign bus.ram_a    = ram_a_q;
  assign bus.ram_dout = ram_dout_q;
  assign bus.ram_wr   = ram_wr_q;

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  mem_arb_if bus();

  mem_arb #(.STARVE_MAX(SM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // RAM device: 4 KiB aliased by the low 12 address bits, one-cycle read latency.
  logic [7:0] dev [0:4095];
  logic [7:0] ref_mem [0:4095];

  function automatic logic [7:0] init_byte(int unsigned i);
    case (i)
      0: return 8'h13;
      1: return 8'h05;
      2: return 8'h00;
      3: return 8'h00;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) dev[i] <= init_byte(i);
    end else if (bus.ram_wr) begin
      dev[bus.ram_a[11:0]] <= bus.ram_dout;
    end
    bus.ram_din <= dev[bus.ram_a[11:0]];
  end

  int total = 0;
  int bad   = 0;
  int streak;
  logic [31:0] last_if, last_mm;
  bit mm_known;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_of(logic [1:0] cu);
    return (cu == 2'd0) ? 1 : (cu == 2'd1) ? 2 : 4;
  endfunction

  // Runs cycles G+1.. of a granted transaction and checks the RAM port and returns.
  task automatic body(bit is_if, bit wr, logic [31:0] a, int n, logic [31:0] wd,
                      int abort_at, bit mm_pend);
    int len;
    logic [31:0] expd, ad, ea;
    len  = wr ? n + 1 : n + 2;
    expd = '0;
    for (int k = 0; k < n; k++) begin
      ad = a + 32'(k);
      expd = expd | (32'(ref_mem[ad[11:0]]) << (8 * k));
    end
    for (int t = 1; t <= len; t++) begin
      cyc();
      if (t == abort_at) begin
        bus.if_abort = 1'b1;
        if (mm_pend) bus.mm_req = 1'b1;
      end
      if (t == len) begin
        bus.if_req = 1'b0;
        bus.mm_req = 1'b0;
      end
      #1;
      ea = (t <= n) ? a + 32'(t - 1) : 32'h0;
      chk("ram_a", bus.ram_a, ea);
      chk("ram_wr", 32'(bus.ram_wr), 32'(wr && t <= n));
      chk("ram_dout", 32'(bus.ram_dout), (wr && t <= n) ? ((wd >> (8 * (t - 1))) & 32'hFF) : 32'h0);
      chk("if_ok", 32'(bus.if_ok), 32'(is_if && t == len && t != abort_at));
      chk("mm_ok", 32'(bus.mm_ok), 32'(!is_if && t == len));
      if (t == abort_at) begin
        chk("if_n_after_abort", bus.if_n, last_if);
        break;
      end
      if (t == len) begin
        if (is_if) begin
          chk("if_n", bus.if_n, expd);
          last_if = expd;
          if (mm_known) chk("mm_n_o_hold", bus.mm_n_o, last_mm);
        end else begin
          chk("if_n_hold", bus.if_n, last_if);
          if (!wr) begin
            chk("mm_n_o", bus.mm_n_o, expd);
            last_mm  = expd;
            mm_known = 1'b1;
          end else begin
            mm_known = 1'b0;
            for (int k = 0; k < n; k++) begin
              ad = a + 32'(k);
              ref_mem[ad[11:0]] = 8'(wd >> (8 * k));
            end
          end
        end
      end
    end
  endtask

  // Drives one IDLE arbitration cycle, predicts the winner and runs it.
  task automatic txn(bit ir, bit mr, bit mwr, logic [31:0] ia, logic [31:0] ma,
                     logic [1:0] cu, logic [31:0] wd, int abort_at, bit mm_pend,
                     output bit win_if);
    cyc();
    bus.if_req   = ir;
    bus.if_a     = ia;
    bus.if_abort = 1'b0;
    bus.mm_req   = mr;
    bus.mm_wr    = mwr;
    bus.mm_a     = ma;
    bus.mm_cu    = cu;
    bus.mm_n_i   = wd;
    #1;
    chk("idle_ram_wr", 32'(bus.ram_wr), 32'h0);
    chk("idle_ram_a", bus.ram_a, 32'h0);
    win_if = ir && (!mr || streak == SM);
    if (win_if) streak = 0;
    else if (ir) streak = (streak < SM) ? streak + 1 : SM;
    else streak = 0;
    if (win_if) body(1'b1, 1'b0, ia, 4, 32'h0, abort_at, mm_pend);
    else        body(1'b0, mwr, ma, size_of(cu), wd, abort_at, mm_pend);
  endtask

  initial begin
    bit w;
    rst = 1'b1;
    mem_init = 1'b1;
    bus.if_req = 1'b0; bus.if_a = '0; bus.if_abort = 1'b0;
    bus.mm_req = 1'b0; bus.mm_wr = 1'b0; bus.mm_a = '0; bus.mm_cu = '0; bus.mm_n_i = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
    streak = 0; last_if = '0; last_mm = '0; mm_known = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_init = 1'b0;
    #1;
    chk("rst_ram_a", bus.ram_a, 32'h0);
    chk("rst_ram_wr", 32'(bus.ram_wr), 32'h0);
    chk("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
    chk("rst_if_ok", 32'(bus.if_ok), 32'h0);
    chk("rst_mm_ok", 32'(bus.mm_ok), 32'h0);
    chk("rst_if_n", bus.if_n, 32'h0);
    chk("rst_mm_n_o", bus.mm_n_o, 32'h0);

    // IF fetch of the known instruction word
    txn(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0, 2'd0, 32'h0, 0, 1'b0, w);
    chk("fetch_word", bus.if_n, 32'h0000_0513);

    // MM store word then half load from the middle of it
    txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 2'd2, 32'hAABBCCDD, 0, 1'b0, w);
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h21, 2'd1, 32'h0, 0, 1'b0, w);
    chk("half_load", bus.mm_n_o, 32'h0000_BBCC);

    // Both requesting continuously: IF wins every fifth grant
    for (int i = 0; i < 10; i++) begin
      txn(1'b1, 1'b1, 1'b0, 32'h1000, 32'h100 + 32'(i), 2'd0, 32'h0, 0, 1'b0, w);
      chk("starve_order", 32'(w), 32'((i % 5) == 4));
    end

    // Abort at G+3 of a fetch, with MM becoming pending; MM granted at G+4
    txn(1'b1, 1'b0, 1'b0, 32'h1008, 32'h30, 2'd2, 32'h0, 3, 1'b1, w);
    cyc();
    bus.if_abort = 1'b0;
    bus.if_req   = 1'b0;
    #1;
    chk("abort_ram_a", bus.ram_a, 32'h0);
    chk("abort_ram_wr", 32'(bus.ram_wr), 32'h0);
    chk("abort_if_ok", 32'(bus.if_ok), 32'h0);
    streak = 0;
    body(1'b0, 1'b0, 32'h30, 4, 32'h0, 0, 1'b0);

    // Abort during DONE of a fetch: no ok and if_n unchanged
    txn(1'b1, 1'b0, 1'b0, 32'h1004, 32'h0, 2'd0, 32'h0, 6, 1'b0, w);
    cyc();
    bus.if_abort = 1'b0;
    #1;
    chk("late_abort_if_n", bus.if_n, last_if);

    // Address wrap on a word load
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFE, 2'd3, 32'h0, 0, 1'b0, w);

    // Randomized mix of requesters, sizes, directions and addresses
    for (int i = 0; i < 40; i++) begin
      bit ir, mr, mwr;
      ir  = 1'($urandom_range(0, 1));
      mr  = ir ? 1'($urandom_range(0, 1)) : 1'b1;
      mwr = 1'($urandom_range(0, 1));
      txn(ir, mr, mwr, $urandom, 32'h200 + 32'($urandom_range(0, 63)),
          2'($urandom_range(0, 3)), $urandom, 0, 1'b0, w);
    end

    // Reset at G+2 of a store
    cyc();
    bus.if_req = 1'b0; bus.mm_req = 1'b1; bus.mm_wr = 1'b1;
    bus.mm_a = 32'h40; bus.mm_cu = 2'd2; bus.mm_n_i = 32'h11223344;
    #1;
    cyc();
    #1;
    chk("rst_txn_wr", 32'(bus.ram_wr), 32'h1);
    chk("rst_txn_dout", 32'(bus.ram_dout), 32'h44);
    cyc();
    rst = 1'b1;
    #1;
    chk("rst_txn_a1", bus.ram_a, 32'h41);
    cyc();
    rst = 1'b0;
    bus.mm_req = 1'b0;
    #1;
    chk("rst2_ram_a", bus.ram_a, 32'h0);
    chk("rst2_ram_wr", 32'(bus.ram_wr), 32'h0);
    chk("rst2_ram_dout", 32'(bus.ram_dout), 32'h0);
    chk("rst2_mm_ok", 32'(bus.mm_ok), 32'h0);
    chk("rst2_if_ok", 32'(bus.if_ok), 32'h0);
    chk("rst2_mm_n_o", bus.mm_n_o, 32'h0);
    chk("rst2_if_n", bus.if_n, 32'h0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      #1;
      chk("post_rst_wr", 32'(bus.ram_wr), 32'h0);
      chk("post_rst_ok", 32'(bus.mm_ok), 32'h0);
    end
    ref_mem[12'h040] = 8'h44;
    ref_mem[12'h041] = 8'h33;
    streak = 0; last_if = '0; last_mm = '0; mm_known = 1'b1;
    txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 2'd2, 32'h0, 0, 1'b0, w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-requester arbiter and byte sequencer for the single 8-bit RAM port of the CPU.
- Shares the port between instruction fetch (IF, read-only) and the memory stage (MM, read/write, byte/half/word).
- Splits each request into little-endian byte accesses and reassembles read data.
- Arbitration is MM-priority with an IF anti-starvation limit. IF requests can be aborted on branch redirect.

Parameters:
- STARVE_MAX, 4, consecutive MM grants allowed while IF is requesting before IF is forced to win.

Ports:
- clk  input  1  system clock; single clock domain
- rst  input  1  reset; synchronous, active-high
- ram_din  input  8  RAM read byte; valid the cycle after its address is driven
- ram_dout  output  8  RAM write byte
- ram_a  output  32  RAM byte address
- ram_wr  output  1  1 = write cycle, 0 = read/idle
- if_req  input  1  IF fetch request, level
- if_a  input  32  IF fetch address
- if_abort  input  1  cancel the current/pending IF fetch
- if_ok  output  1  one-cycle pulse: if_n valid
- if_n  output  32  fetched word
- mm_req  input  1  MM request, level
- mm_wr  input  1  1 = store, 0 = load
- mm_a  input  32  MM byte address
- mm_cu  input  2  size: 0 = byte, 1 = half, 2 = word, 3 = word (reserved alias)
- mm_n_i  input  32  store data; byte k = bits [8k+7:8k]
- mm_ok  output  1  one-cycle pulse: transaction complete; mm_n_o valid for loads
- mm_n_o  output  32  load data, zero-extended

Behaviour:
- States: IDLE, RD, WR, DONE.
- Reset (rst=1 at a clk edge):
  - state=IDLE, ram_a=0, ram_dout=0, ram_wr=0, if_ok=0, mm_ok=0, if_n=0, mm_n_o=0, streak=0.
  - Reset mid-transaction drops the transaction; no ok is issued.
- IDLE, arbitration at cycle G:
  - Only mm_req: MM granted.
  - Only if_req and if_abort=0: IF granted.
  - Both: MM granted unless streak==STARVE_MAX, then IF granted.
  - if_req with if_abort=1 in the same cycle is ignored.
  - On grant, latch address, direction, size N (IF always N=4), and write data. Input changes after G are ignored.
- Streak counter:
  - Increments (saturating at STARVE_MAX) on an MM grant while if_req is high.
  - Clears on an IF grant, and on an MM grant while if_req is low.
- RD (N bytes):
  - Cycles G+1..G+N drive ram_a=base+k (k=0..N-1, modulo 2^32), ram_wr=0.
  - Byte k is captured from ram_din at cycle G+k+2 into lane k.
  - Cycle G+N+1 is a capture-only cycle: ram_a=0, ram_wr=0.
  - DONE at G+N+2.
- WR (N bytes):
  - Cycles G+1..G+N drive ram_a=base+k, ram_dout=byte k, ram_wr=1.
  - DONE at G+N+1.
- DONE:
  - Pulses the grantee's ok for one cycle, with if_n / mm_n_o holding the assembled word.
  - Unused upper bytes are 0.
  - Next state is IDLE.
- Data outputs hold their last value until the next completion of the same requester.
- Outside issue cycles: ram_a=0, ram_wr=0, ram_dout=0.
- Requesters drop req in the cycle after seeing ok. A req still high in the following IDLE starts a new transaction (minimum gap: DONE + IDLE).
- if_abort during an IF transaction (RD, or DONE for IF):
  - Remaining issues are cancelled and any outstanding ram_din byte is discarded.
  - No if_ok; next state is IDLE; if_n is unchanged.
- if_abort has no effect on MM transactions.
- Unaligned addresses are legal and sequence bytewise; address wraps 0xFFFFFFFF -> 0x00000000.

Test Plan:
- IF fetch, if_a=0x1000, RAM[0x1000..3]=13,05,00,00, grant at G:
  - Expect ram_a 0x1000..0x1003 at G+1..G+4, if_ok=1 at G+6 only, if_n=0x00000513.
- MM store word, mm_a=0x20, mm_n_i=0xAABBCCDD:
  - Expect ram_wr=1 at G+1..G+4 with (0x20,DD),(0x21,CC),(0x22,BB),(0x23,AA), mm_ok at G+5.
  - Then MM load half from 0x21 returns mm_n_o=0x0000BBCC with mm_ok at G'+4.
- Both requesting continuously, STARVE_MAX=4, MM byte loads:
  - Expect grant order MM,MM,MM,MM,IF,MM...; streak returns to 0 after the IF grant.
- if_abort asserted at G+3 of an IF fetch:
  - Expect no if_ok, ram_wr=0 and ram_a=0 from G+4, IDLE at G+4.
  - A pending mm_req is granted at G+4.
- rst asserted at G+2 of an MM store:
  - Expect all outputs 0 next cycle, no mm_ok, and no further ram_wr pulses.
- Address wrap, byte-sequenced word load at 0xFFFFFFFE:
  - Expect ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
